integer_divider: RTL and testbench
==================================

Name: integer_divider

Overview:
- Iterative 32-bit integer divide/remainder unit covering the RV32M DIV, DIVU, REM and REMU operations.
- It is the inverse-operation companion to the combinational ALU and sits beside it in the execute stage.
- Radix-2 restoring algorithm on operand magnitudes, one quotient bit per cycle, with a start/done handshake to the pipeline control.

Parameters:
- WIDTH, 32, operand and result width in bits; only 32 is required to be supported.
- COUNT_BITS, 5, width of the iteration counter (log2 WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a new operation; sampled only in IDLE.
- abort  input  1  pipeline flush; abandons the in-flight operation.
- is_signed  input  1  1 = DIV/REM (two's complement), 0 = DIVU/REMU; sampled with start.
- want_rem  input  1  1 = return remainder, 0 = return quotient; sampled with start.
- dividend  input  WIDTH  numerator; sampled with start.
- divisor  input  WIDTH  denominator; sampled with start.
- busy  output  1  high in CALC and DONE states.
- done  output  1  one-cycle pulse; result is valid in that cycle.
- result  output  WIDTH  quotient or remainder; held after done until the next accepted start.

Behaviour:
- Reset (async, any time, including mid-operation): state=IDLE, busy=0, done=0, result=0, counter=0, all internal registers cleared. No done is produced for an interrupted operation.
- States:
  - IDLE: start=1 latches operands, is_signed and want_rem, then goes to CALC with counter=0. start=0 stays in IDLE.
  - CALC: one restoring step per edge; counter increments; after the 32nd step (counter==31 at the edge) goes to DONE.
  - DONE: done=1 for exactly one cycle, result is registered with sign fixup, then returns to IDLE.
- Latency: start sampled at edge 0; CALC occupies cycles 1..32; done=1 in cycle 33. It is 33 cycles fixed for all operands, including special cases.
- Back-to-back: start is ignored in CALC and DONE. A start asserted in the DONE cycle is not accepted; the earliest next acceptance is the IDLE cycle after done.
- abort: in CALC or DONE it forces IDLE at the next edge, done stays 0 and result is unchanged. abort in IDLE has no effect. abort and start in the same IDLE cycle: abort wins and no operation starts.
- Magnitudes:
  - If is_signed and the operand MSB is 1, the operand magnitude is its two's-complement negation; otherwise the raw value is used.
  - Partial remainder register is WIDTH+1 bits. Each step shifts {rem, quo} left by 1, trial-subtracts the divisor magnitude, keeps the difference and sets the quotient LSB when non-negative.
- Sign fixup (signed only):
  - quotient is negated iff dividend and divisor signs differ.
  - remainder is negated iff the dividend is negative.
- Divisor == 0, forced regardless of signedness: quotient = 0xFFFFFFFF, remainder = dividend (unmodified).
- Signed overflow (dividend 0x80000000, divisor 0xFFFFFFFF): quotient = 0x80000000, remainder = 0. This falls out of the magnitude/fixup path and must not trap.
- No exceptions and no other status outputs.

Test Plan:
- Reset, then DIVU 100/7 (start pulse, is_signed=0, want_rem=0) -> busy=1 cycles 1..33, done=1 only in cycle 33, result=14; REMU same operands -> result=2.
- Signed DIV -7/2 (0xFFFFFFF9, 2) -> result 0xFFFFFFFD (-3); REM -> 0xFFFFFFFF (-1); REM 7/-2 -> 1.
- Divisor 0: DIV 0xFFFFFFF9/0 -> 0xFFFFFFFF; REMU 1234/0 -> 1234; latency still 33 cycles.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- Assert abort at cycle 10 of a DIVU -> IDLE next edge, done never pulses, result keeps its previous value; start pulses during CALC and in the DONE cycle are ignored.
- Assert reset asynchronously mid-CALC (between clock edges) -> busy, done, result go 0 immediately; a subsequent DIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF.

Source files
------------

// File: rtl/integer_divider.sv
// ============================================================================
// Module   : integer_divider
// Brief    : Iterative radix-2 restoring divide/remainder unit (RV32M DIV/DIVU/REM/REMU).
// Revision : 1.0
// ============================================================================
`default_nettype none

module integer_divider #(
    parameter int WIDTH      = 32,
    parameter int COUNT_BITS = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             is_signed,
    input  logic             want_rem,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [COUNT_BITS-1:0] c_last_count = COUNT_BITS'(WIDTH - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [COUNT_BITS-1:0] r_count;
    logic [WIDTH:0]        r_rem;
    logic [WIDTH-1:0]      r_quo;
    logic [WIDTH-1:0]      r_dmag;
    logic [WIDTH-1:0]      r_dividend;
    logic                  r_want_rem;
    logic                  r_neg_q;
    logic                  r_neg_r;
    logic                  r_div_zero;
    logic [WIDTH-1:0]      r_result;

    logic                  w_dividend_neg;
    logic                  w_divisor_neg;
    logic [WIDTH-1:0]      w_dividend_mag;
    logic [WIDTH-1:0]      w_divisor_mag;
    logic                  w_accept;
    logic [WIDTH+1:0]      w_shift;
    logic [WIDTH+1:0]      w_diff;
    logic                  w_fits;
    logic [WIDTH-1:0]      w_quo_fix;
    logic [WIDTH-1:0]      w_rem_fix;
    logic [WIDTH-1:0]      w_final;

    assign w_dividend_neg = is_signed & dividend[WIDTH-1];
    assign w_divisor_neg  = is_signed & divisor[WIDTH-1];
    assign w_dividend_mag = w_dividend_neg ? (~dividend + 1'b1) : dividend;
    assign w_divisor_mag  = w_divisor_neg  ? (~divisor  + 1'b1) : divisor;
    assign w_accept       = (r_state == S_IDLE) & start & ~abort;

    // Two guard bits keep the trial-subtraction sign separate from the remainder MSB.
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_diff  = w_shift - {2'b00, r_dmag};
    assign w_fits  = ~w_diff[WIDTH+1];

    assign w_quo_fix = r_neg_q ? (~r_quo + 1'b1) : r_quo;
    assign w_rem_fix = r_neg_r ? (~r_rem[WIDTH-1:0] + 1'b1) : r_rem[WIDTH-1:0];

    always_comb begin
        w_final = r_want_rem ? w_rem_fix : w_quo_fix;
        if (r_div_zero) begin
            w_final = r_want_rem ? r_dividend : {WIDTH{1'b1}};
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_next = S_CALC;
            S_CALC: begin
                if (abort)                        w_state_next = S_IDLE;
                else if (r_count == c_last_count) w_state_next = S_DONE;
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count    <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_dmag     <= '0;
            r_dividend <= '0;
            r_want_rem <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
            r_result   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_count    <= '0;
                        r_rem      <= '0;
                        r_quo      <= w_dividend_mag;
                        r_dmag     <= w_divisor_mag;
                        r_dividend <= dividend;
                        r_want_rem <= want_rem;
                        r_neg_q    <= w_dividend_neg ^ w_divisor_neg;
                        r_neg_r    <= w_dividend_neg;
                        r_div_zero <= (divisor == '0);
                    end
                end
                S_CALC: begin
                    r_count <= r_count + 1'b1;
                    r_rem   <= w_fits ? w_diff[WIDTH:0] : w_shift[WIDTH:0];
                    r_quo   <= {r_quo[WIDTH-2:0], w_fits};
                end
                S_DONE: begin
                    if (!abort) r_result <= w_final;
                end
                default: ;
            endcase
        end
    end

    // The result is presented during the done cycle and held in r_result afterwards.
    assign busy   = (r_state != S_IDLE);
    assign done   = (r_state == S_DONE) & ~abort;
    assign result = done ? w_final : r_result;

endmodule

`default_nettype wire

// File: tb/tb_integer_divider.sv
// ============================================================================
// Module   : tb_integer_divider
// Brief    : Directed self-checking bench for integer_divider.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_integer_divider;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic        is_signed;
    logic        want_rem;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    integer_divider #(.WIDTH(32), .COUNT_BITS(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .is_signed (is_signed),
        .want_rem  (want_rem),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    always #5 clk = ~clk;

    // Issue one operation and observe 40 cycles; cycle 1 follows the accepting edge.
    task automatic run_op(input logic s, input logic r, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int done_cyc, output int n_done,
                          output int n_busy);
        res = '0; done_cyc = 0; n_done = 0; n_busy = 0;
        @(negedge clk);
        is_signed = s; want_rem = r; dividend = a; divisor = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (busy) n_busy++;
            if (done) begin
                n_done++;
                done_cyc = c;
                res = result;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0; is_signed = 1'b0; want_rem = 1'b0;
        dividend = '0; divisor = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b result=%h, required 0 0 00000000", busy, done, result);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_unsigned();
        logic [31:0] res;
        int dc, nd, nb;
        run_op(1'b0, 1'b0, 32'd100, 32'd7, res, dc, nd, nb);
        checks++;
        if (res !== 32'd14) begin
            errors++; $display("FAIL divu_100_7: got %h, required %h", res, 32'd14);
        end
        checks++;
        if (dc !== 33 || nd !== 1 || nb !== 33) begin
            errors++; $display("FAIL divu_timing: done_cycle=%0d done_count=%0d busy_cycles=%0d, required 33 1 33", dc, nd, nb);
        end
        checks++;
        if (result !== 32'd14) begin
            errors++; $display("FAIL divu_hold: got %h, required %h", result, 32'd14);
        end
        run_op(1'b0, 1'b1, 32'd100, 32'd7, res, dc, nd, nb);
        checks++;
        if (res !== 32'd2) begin
            errors++; $display("FAIL remu_100_7: got %h, required %h", res, 32'd2);
        end
    endtask

    task automatic test_signed();
        logic [31:0] res;
        int dc, nd, nb;
        run_op(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, res, dc, nd, nb);
        checks++;
        if (res !== 32'hFFFF_FFFD) begin
            errors++; $display("FAIL div_m7_2: got %h, required %h", res, 32'hFFFF_FFFD);
        end
        run_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, res, dc, nd, nb);
        checks++;
        if (res !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL rem_m7_2: got %h, required %h", res, 32'hFFFF_FFFF);
        end
        run_op(1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE, res, dc, nd, nb);
        checks++;
        if (res !== 32'd1) begin
            errors++; $display("FAIL rem_7_m2: got %h, required %h", res, 32'd1);
        end
        run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFE, res, dc, nd, nb);
        checks++;
        if (res !== 32'hFFFF_FFFD) begin
            errors++; $display("FAIL div_7_m2: got %h, required %h", res, 32'hFFFF_FFFD);
        end
    endtask

    task automatic test_div_zero();
        logic [31:0] res;
        int dc, nd, nb;
        run_op(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd0, res, dc, nd, nb);
        checks++;
        if (res !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL div_by_zero: got %h, required %h", res, 32'hFFFF_FFFF);
        end
        run_op(1'b0, 1'b1, 32'd1234, 32'd0, res, dc, nd, nb);
        checks++;
        if (res !== 32'd1234) begin
            errors++; $display("FAIL remu_by_zero: got %h, required %h", res, 32'd1234);
        end
        checks++;
        if (dc !== 33 || nd !== 1) begin
            errors++; $display("FAIL zero_latency: done_cycle=%0d done_count=%0d, required 33 1", dc, nd);
        end
        run_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd0, res, dc, nd, nb);
        checks++;
        if (res !== 32'hFFFF_FFF9) begin
            errors++; $display("FAIL rem_by_zero: got %h, required %h", res, 32'hFFFF_FFF9);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] res;
        int dc, nd, nb;
        run_op(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, res, dc, nd, nb);
        checks++;
        if (res !== 32'h8000_0000) begin
            errors++; $display("FAIL ovf_div: got %h, required %h", res, 32'h8000_0000);
        end
        run_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, res, dc, nd, nb);
        checks++;
        if (res !== 32'h0) begin
            errors++; $display("FAIL ovf_rem: got %h, required %h", res, 32'h0);
        end
    endtask

    task automatic test_abort();
        logic [31:0] res;
        int dc, nd, nb, busy34;
        run_op(1'b0, 1'b1, 32'd100, 32'd7, res, dc, nd, nb);
        checks++;
        if (res !== 32'd2) begin
            errors++; $display("FAIL abort_setup: got %h, required %h", res, 32'd2);
        end
        // Abort in cycle 10 of a DIVU.
        @(negedge clk);
        is_signed = 1'b0; want_rem = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL abort_idle: busy=%b, required 0", busy);
        end
        nd = 0;
        for (int c = 0; c < 40; c++) begin
            if (done) nd++;
            @(negedge clk);
        end
        checks++;
        if (nd !== 0 || result !== 32'd2) begin
            errors++; $display("FAIL abort_no_done: done_count=%0d result=%h, required 0 %h", nd, result, 32'd2);
        end
        // abort and start together in IDLE: nothing starts.
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL abort_beats_start: busy=%b, required 0", busy);
        end
        // Start pulses in CALC and in the DONE cycle are ignored.
        is_signed = 1'b0; want_rem = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dc = 0; nd = 0; busy34 = 0; res = '0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 34) busy34 = int'(busy);
            if (done) begin
                nd++; dc = c; res = result;
            end
            start = (c == 5) || done;
            if (start) begin
                dividend = 32'd1000; divisor = 32'd1;
            end
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (res !== 32'd14 || dc !== 33 || nd !== 1) begin
            errors++; $display("FAIL start_ignored: result=%h done_cycle=%0d done_count=%0d, required %h 33 1", res, dc, nd, 32'd14);
        end
        checks++;
        if (busy34 !== 0) begin
            errors++; $display("FAIL start_in_done: busy after done=%0d, required 0", busy34);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] res;
        int dc, nd, nb;
        @(negedge clk);
        is_signed = 1'b0; want_rem = 1'b0; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            errors++; $display("FAIL async_reset: busy=%b done=%b result=%h, required 0 0 00000000", busy, done, result);
        end
        @(negedge clk);
        reset = 1'b0;
        run_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, res, dc, nd, nb);
        checks++;
        if (res !== 32'hFFFF_FFFF || dc !== 33) begin
            errors++; $display("FAIL post_reset_divu: result=%h done_cycle=%0d, required %h 33", res, dc, 32'hFFFF_FFFF);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_abort();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
